// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS data-memory bus bridge.
// State and error encodings used by the bridge and its bench.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } dmem_state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ALIGN,
    ERR_TMO,
    ERR_RDWR
  } dmem_err_e;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Counts BUSY cycles without a bus ack.
// expired is high in the last allowed cycle.
module bus_timeout_ctr #(
  parameter int TMO_CYC = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CW'(TMO_CYC - 1));

endmodule

// File: rtl/mips_dmem_bridge.sv
// Single-cycle MIPS data port to req/ack bus bridge.
// Stalls the core per access; flags misalign/timeout/rd+wr.
module mips_dmem_bridge
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  input  logic              err_clr,
  output logic              err,
  output logic [1:0]        err_code
);

  dmem_state_e state, state_nxt;
  dmem_err_e   code_q, new_code;

  logic access, aligned;
  logic start, accept, misalign;
  logic ack_hit, tmo, expired;
  logic tmr_clr, tmr_en;
  logic new_err;

  assign access   = memread | memwrite;
  assign aligned  = (addr[1:0] == 2'b00);
  assign start    = (state == IDLE) && access;
  assign accept   = start && aligned;
  assign misalign = start && !aligned;
  assign ack_hit  = (state == BUSY) && bus_ack;
  assign tmo      = (state == BUSY) && !bus_ack && expired;

  bus_timeout_ctr #(
    .TMO_CYC(TMO_CYC)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
        end else if (misalign) begin
          state_nxt = DONE;
        end
      end
      BUSY: begin
        if (ack_hit || tmo) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall   = start || (state == BUSY);
    tmr_clr = accept;
    tmr_en  = (state == BUSY);
  end

  // Misalign outranks rd+wr: no bus cycle is issued for it.
  always_comb begin
    new_err  = 1'b1;
    new_code = ERR_NONE;
    unique case (1'b1)
      misalign:                        new_code = ERR_ALIGN;
      accept && memread && memwrite:   new_code = ERR_RDWR;
      tmo:                             new_code = ERR_TMO;
      default:                         new_err  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      readdata  <= '0;
    end else begin
      if (accept) begin
        bus_req   <= 1'b1;
        bus_we    <= memwrite;
        bus_addr  <= addr;
        bus_wdata <= writedata;
      end
      if (misalign) begin
        readdata <= '0;
      end
      if (ack_hit) begin
        bus_req <= 1'b0;
        if (!bus_we) begin
          readdata <= bus_rdata;
        end
      end
      if (tmo) begin
        bus_req  <= 1'b0;
        readdata <= '0;
      end
    end
  end

  // First error sticks; a clear in the same cycle lets the new one in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err    <= 1'b0;
      code_q <= ERR_NONE;
    end else if (new_err) begin
      err <= 1'b1;
      if (!err || err_clr) begin
        code_q <= new_code;
      end
    end else if (err_clr) begin
      err    <= 1'b0;
      code_q <= ERR_NONE;
    end
  end

  assign err_code = code_q;

endmodule

// File: tb/tb_mips_dmem_bridge.sv
// Directed plus randomized bench for mips_dmem_bridge.
// Expected results come from a transaction-level model.
module tb_mips_dmem_bridge;

  localparam int TMO = 15;

  logic        clk;
  logic        reset;
  logic        memread, memwrite;
  logic [31:0] addr, writedata, readdata;
  logic        stall;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;
  logic        err_clr, err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_rd;
  logic        exp_err;
  logic [1:0]  exp_code;

  mips_dmem_bridge #(
    .ADDR_W (32),
    .DATA_W (32),
    .TMO_CYC(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memread  (memread),
    .memwrite (memwrite),
    .addr     (addr),
    .writedata(writedata),
    .readdata (readdata),
    .stall    (stall),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack),
    .err_clr  (err_clr),
    .err      (err),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One core access. ack_at: BUSY cycle (1-based) that gets bus_ack.
  task automatic access(input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdv, input int ack_at,
                        input bit clr, input bit late_ack);
    int stalls = 0;
    int reqs = 0;
    bit done = 0;
    bit mis;
    bit tmo;
    logic [1:0] idle_err;
    mis = (a[1:0] != 2'b00);
    tmo = !mis && (ack_at > TMO);
    @(negedge clk);
    memread = rd; memwrite = wr; addr = a; writedata = wd;
    err_clr = clr; bus_ack = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (stall) stalls++;
      if (bus_req) begin
        reqs++;
        chk("bus_we", {31'd0, bus_we}, {31'd0, wr});
        chk("bus_addr", bus_addr, a);
        if (wr) chk("bus_wdata", bus_wdata, wd);
        if (reqs == ack_at) begin
          bus_ack = 1'b1;
          bus_rdata = rdv;
        end
      end
      if (!stall) begin
        done = 1;
      end else begin
        @(negedge clk);
        err_clr = 1'b0;
        bus_ack = 1'b0;
        bus_rdata = $urandom;
      end
    end
    // Model: plain outcome of one transaction.
    if (mis || tmo) exp_rd = 32'd0;
    else if (!wr) exp_rd = rdv;
    idle_err = mis ? 2'b01 : (rd && wr) ? 2'b11 : 2'b00;
    if (idle_err != 2'b00) begin
      if (!exp_err || clr) exp_code = idle_err;
      exp_err = 1'b1;
    end else if (clr) begin
      exp_err = 1'b0;
      exp_code = 2'b00;
    end
    if (tmo) begin
      if (!exp_err) exp_code = 2'b10;
      exp_err = 1'b1;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("stall_cycles", stalls,
        mis ? 1 : tmo ? TMO + 1 : ack_at + 1);
    chk("req_cycles", reqs, mis ? 0 : tmo ? TMO : ack_at);
    chk("readdata_done", readdata, exp_rd);
    chk("err_done", {31'd0, err}, {31'd0, exp_err});
    chk("err_code_done", {30'd0, err_code}, {30'd0, exp_code});
    if (late_ack) begin
      bus_ack = 1'b1;
      bus_rdata = 32'hFFFF_FFFF;
    end
    @(negedge clk);
    memread = 1'b0; memwrite = 1'b0; bus_ack = 1'b0; err_clr = 1'b0;
    #1;
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_req", {31'd0, bus_req}, 32'd0);
    chk("idle_readdata", readdata, exp_rd);
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    exp_code = 2'b00;
    #1;
    chk("clr_err", {31'd0, err}, 32'd0);
    chk("clr_code", {30'd0, err_code}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    memread = 1'b0; memwrite = 1'b0;
    addr = '0; writedata = '0;
    bus_rdata = '0; bus_ack = 1'b0; err_clr = 1'b0;
    exp_rd = '0; exp_err = 1'b0; exp_code = 2'b00;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_code", {30'd0, err_code}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    access(1, 0, 32'h40, 32'h0, 32'h1234_5678, 1, 0, 0);
    access(0, 1, 32'h44, 32'hCAFE_F00D, 32'h0, 3, 0, 0);
    access(1, 0, 32'h42, 32'h0, 32'h5555_5555, 1, 0, 0);
    clear_err();
    access(1, 0, 32'h80, 32'h0, 32'h0, 99, 0, 1);
    access(1, 0, 32'h81, 32'h0, 32'h0, 1, 1, 0);
    clear_err();

    // Reset asserted in the second BUSY cycle.
    @(negedge clk);
    memread = 1'b1; addr = 32'h80;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("busy2_req", {31'd0, bus_req}, 32'd1);
    reset = 1'b0;
    memread = 1'b0;
    #1;
    chk("abort_req", {31'd0, bus_req}, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_rd = '0; exp_err = 1'b0; exp_code = 2'b00;
    access(1, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 0, 0);

    access(1, 1, 32'h10, 32'hA5A5_5A5A, 32'h0, 2, 0, 0);
    clear_err();

    for (int n = 0; n < 40; n++) begin
      bit rd, wr, clr;
      logic [31:0] a;
      logic [1:0] lo;
      int ack_at;
      lo = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | {30'd0, lo};
      rd = $urandom_range(0, 1) == 1;
      wr = !rd;
      if (lo == 2'b00 && $urandom_range(0, 7) == 0) begin
        rd = 1; wr = 1;
      end
      ack_at = $urandom_range(1, 18);
      clr = $urandom_range(0, 3) == 0;
      access(rd, wr, a, $urandom, $urandom, ack_at, clr,
             $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
